// File: rtl/cosine_lut.sv
// cosine_lut: registered 512-step cosine generator built from a quarter-wave table.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset, forces out to 0
//   in  - phase index 0..511, angle = 2*pi*in/512
//   out - signed cosine sample round(131071*cos(angle)), one cycle after in is sampled
module cosine_lut #(
    parameter int PHASE_W = 9,
    parameter int DATA_W  = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PHASE_W-1:0] in,
    output logic [DATA_W-1:0]  out
);
    logic [7:0]        idx;
    logic [16:0]       mag;
    logic              neg;
    logic [DATA_W-1:0] val;

    // Magnitudes for the first quadrant, k = 0..128 inclusive so the mirror
    // index 128-k never needs a special case.
    function automatic logic [16:0] quarter(input logic [7:0] k);
        case (k)
            8'd0:   quarter = 17'd131071;
            8'd1:   quarter = 17'd131061;
            8'd2:   quarter = 17'd131032;
            8'd3:   quarter = 17'd130982;
            8'd4:   quarter = 17'd130913;
            8'd5:   quarter = 17'd130824;
            8'd6:   quarter = 17'd130716;
            8'd7:   quarter = 17'd130588;
            8'd8:   quarter = 17'd130440;
            8'd9:   quarter = 17'd130272;
            8'd10:  quarter = 17'd130085;
            8'd11:  quarter = 17'd129879;
            8'd12:  quarter = 17'd129652;
            8'd13:  quarter = 17'd129407;
            8'd14:  quarter = 17'd129141;
            8'd15:  quarter = 17'd128857;
            8'd16:  quarter = 17'd128553;
            8'd17:  quarter = 17'd128229;
            8'd18:  quarter = 17'd127886;
            8'd19:  quarter = 17'd127524;
            8'd20:  quarter = 17'd127143;
            8'd21:  quarter = 17'd126743;
            8'd22:  quarter = 17'd126323;
            8'd23:  quarter = 17'd125885;
            8'd24:  quarter = 17'd125427;
            8'd25:  quarter = 17'd124951;
            8'd26:  quarter = 17'd124456;
            8'd27:  quarter = 17'd123942;
            8'd28:  quarter = 17'd123409;
            8'd29:  quarter = 17'd122858;
            8'd30:  quarter = 17'd122288;
            8'd31:  quarter = 17'd121700;
            8'd32:  quarter = 17'd121094;
            8'd33:  quarter = 17'd120469;
            8'd34:  quarter = 17'd119826;
            8'd35:  quarter = 17'd119166;
            8'd36:  quarter = 17'd118487;
            8'd37:  quarter = 17'd117790;
            8'd38:  quarter = 17'd117076;
            8'd39:  quarter = 17'd116344;
            8'd40:  quarter = 17'd115594;
            8'd41:  quarter = 17'd114827;
            8'd42:  quarter = 17'd114043;
            8'd43:  quarter = 17'd113242;
            8'd44:  quarter = 17'd112423;
            8'd45:  quarter = 17'd111588;
            8'd46:  quarter = 17'd110736;
            8'd47:  quarter = 17'd109867;
            8'd48:  quarter = 17'd108982;
            8'd49:  quarter = 17'd108080;
            8'd50:  quarter = 17'd107162;
            8'd51:  quarter = 17'd106227;
            8'd52:  quarter = 17'd105277;
            8'd53:  quarter = 17'd104311;
            8'd54:  quarter = 17'd103329;
            8'd55:  quarter = 17'd102332;
            8'd56:  quarter = 17'd101319;
            8'd57:  quarter = 17'd100291;
            8'd58:  quarter = 17'd99248;
            8'd59:  quarter = 17'd98190;
            8'd60:  quarter = 17'd97117;
            8'd61:  quarter = 17'd96030;
            8'd62:  quarter = 17'd94928;
            8'd63:  quarter = 17'd93812;
            8'd64:  quarter = 17'd92681;
            8'd65:  quarter = 17'd91537;
            8'd66:  quarter = 17'd90379;
            8'd67:  quarter = 17'd89207;
            8'd68:  quarter = 17'd88022;
            8'd69:  quarter = 17'd86823;
            8'd70:  quarter = 17'd85612;
            8'd71:  quarter = 17'd84388;
            8'd72:  quarter = 17'd83151;
            8'd73:  quarter = 17'd81901;
            8'd74:  quarter = 17'd80639;
            8'd75:  quarter = 17'd79365;
            8'd76:  quarter = 17'd78079;
            8'd77:  quarter = 17'd76781;
            8'd78:  quarter = 17'd75472;
            8'd79:  quarter = 17'd74151;
            8'd80:  quarter = 17'd72819;
            8'd81:  quarter = 17'd71476;
            8'd82:  quarter = 17'd70123;
            8'd83:  quarter = 17'd68758;
            8'd84:  quarter = 17'd67384;
            8'd85:  quarter = 17'd65999;
            8'd86:  quarter = 17'd64605;
            8'd87:  quarter = 17'd63200;
            8'd88:  quarter = 17'd61786;
            8'd89:  quarter = 17'd60363;
            8'd90:  quarter = 17'd58931;
            8'd91:  quarter = 17'd57490;
            8'd92:  quarter = 17'd56040;
            8'd93:  quarter = 17'd54582;
            8'd94:  quarter = 17'd53115;
            8'd95:  quarter = 17'd51641;
            8'd96:  quarter = 17'd50159;
            8'd97:  quarter = 17'd48669;
            8'd98:  quarter = 17'd47172;
            8'd99:  quarter = 17'd45668;
            8'd100: quarter = 17'd44156;
            8'd101: quarter = 17'd42639;
            8'd102: quarter = 17'd41115;
            8'd103: quarter = 17'd39584;
            8'd104: quarter = 17'd38048;
            8'd105: quarter = 17'd36506;
            8'd106: quarter = 17'd34958;
            8'd107: quarter = 17'd33405;
            8'd108: quarter = 17'd31848;
            8'd109: quarter = 17'd30285;
            8'd110: quarter = 17'd28718;
            8'd111: quarter = 17'd27146;
            8'd112: quarter = 17'd25571;
            8'd113: quarter = 17'd23991;
            8'd114: quarter = 17'd22408;
            8'd115: quarter = 17'd20822;
            8'd116: quarter = 17'd19232;
            8'd117: quarter = 17'd17640;
            8'd118: quarter = 17'd16044;
            8'd119: quarter = 17'd14447;
            8'd120: quarter = 17'd12847;
            8'd121: quarter = 17'd11246;
            8'd122: quarter = 17'd9642;
            8'd123: quarter = 17'd8037;
            8'd124: quarter = 17'd6431;
            8'd125: quarter = 17'd4824;
            8'd126: quarter = 17'd3217;
            8'd127: quarter = 17'd1608;
            default: quarter = 17'd0;
        endcase
    endfunction

    // Odd quadrants read the table mirrored (128-k); quadrants 1 and 2 are negative.
    always_comb begin
        idx = in[7] ? 8'd128 - {1'b0, in[6:0]} : {1'b0, in[6:0]};
        mag = quarter(idx);
        neg = in[8] ^ in[7];
        val = neg ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out <= '0;
        else
            out <= val;
    end
endmodule

// File: tb/tb_cosine_lut.sv
// tb_cosine_lut: scoreboard bench for cosine_lut against a real-valued cosine model.
module tb_cosine_lut;
    logic        clk;
    logic        rst;
    logic [8:0]  in;
    logic [17:0] out;

    typedef struct {
        int p;
        int exp;
        bit sw;
    } ent_t;

    ent_t q[$];
    int   obs[512];
    int   tests = 0;
    int   fails = 0;

    cosine_lut dut (
        .clk(clk),
        .rst(rst),
        .in (in),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model(input int p);
        real r;
        r = 131071.0 * $cos(2.0 * 3.141592653589793 * real'(p) / 512.0);
        return (r >= 0.0) ? int'($floor(r + 0.5)) : -int'($floor(-r + 0.5));
    endfunction

    task automatic cmp(input string name, input int p, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s p=%0d got %0d expected %0d", name, p, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit r, input int p, input int exp, input bit sw);
        ent_t e;
        @(negedge clk);
        in = p[8:0];
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            cmp("async_rst", p, int'($signed(out)), 0);
        end else begin
            rst = r;
        end
        e.p = r ? -1 : p;
        e.exp = r ? 0 : exp;
        e.sw = sw;
        q.push_back(e);
    endtask

    always begin
        ent_t e;
        int   got;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            got = int'($signed(out));
            if (e.sw)
                obs[e.p] = got;
            cmp(e.p < 0 ? "reset_out" : "out", e.p, got, e.exp);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog p=-1 got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pts[8];
        int vals[8];
        int rpos;
        int rlen;
        int p;
        bit r;
        pts  = '{0, 128, 256, 384, 64, 192, 320, 448};
        vals = '{131071, 0, -131071, 0, 92681, -92681, -92681, 92681};
        rst = 1'b1;
        in = 9'd0;
        repeat (2) @(negedge clk);
        #1;
        cmp("reset_hold", 0, int'($signed(out)), 0);
        step(0, 0, 131071, 0);
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(511, 0));
            step(0, p, model(p), 0);
        end
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 131071, 0);
        for (int i = 0; i < 8; i++)
            step(0, pts[i], vals[i], 0);
        for (int i = 0; i < 512; i++)
            step(0, i, model(i), 1);
        step(0, 0, 131071, 0);
        step(0, 1, 131061, 0);
        step(0, 511, 131061, 0);
        step(0, 0, 131071, 0);
        for (int i = 1; i < 512; i++)
            cmp("sym_mirror", i, obs[i], obs[512 - i]);
        for (int i = 0; i < 256; i++)
            cmp("sym_half", i, obs[i + 256], -obs[i]);
        rpos = int'($urandom_range(900, 200));
        rlen = int'($urandom_range(3, 1));
        for (int i = 0; i < 1200; i++) begin
            p = int'($urandom_range(511, 0));
            r = (i >= rpos) && (i < rpos + rlen);
            step(r, p, model(p), 0);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge clk);
        #2;
        cmp("drain", -1, q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
